// File: rtl/pipelined_decode_ctrl_if.sv
// rtl/pipelined_decode_ctrl_if.sv - issue/execute handshake bundle for the decode/control stage
interface pipelined_decode_ctrl_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst_i;
  logic [PC_W-1:0]   pc4_i;
  logic              out_valid;
  logic              out_ready;
  logic              flush_i;
  logic [31:0]       ctrl_o;
  logic [PC_W-1:0]   pc4_o;
  logic              illegal_o;

  modport master (
    output in_valid, inst_i, pc4_i, out_ready, flush_i,
    input  in_ready, out_valid, ctrl_o, pc4_o, illegal_o
  );

  modport slave (
    input  in_valid, inst_i, pc4_i, out_ready, flush_i,
    output in_ready, out_valid, ctrl_o, pc4_o, illegal_o
  );
endinterface

// File: rtl/pipelined_decode_ctrl.sv
// rtl/pipelined_decode_ctrl.sv - registered MIPS decode/control stage with MUL busy window
module pipelined_decode_ctrl #(
  parameter int INST_W      = 32,
  parameter int PC_W        = 32,
  parameter int MUL_LATENCY = 3,
  parameter int EN_SPECIAL2 = 1
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_decode_ctrl_if.slave bus
);

  if (INST_W != 32) begin : g_inst_w_check
    $error("pipelined_decode_ctrl: INST_W must be 32");
  end
  if (MUL_LATENCY < 1) begin : g_mul_lat_check
    $error("pipelined_decode_ctrl: MUL_LATENCY must be >= 1");
  end

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] alu_a_src;
    logic [2:0] alu_b_src;
    logic [1:0] reg_dst;
    logic [1:0] reg_data_sel;
    logic       reg_write;
    logic       reg_write_sel;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] bhw;
    logic       dmem_ext_sign;
    logic       ext_sign;
    logic       beq;
    logic       bne;
    logic       bltz_bgtz;
    logic       bgez;
    logic       jump;
    logic       jump_sel;
    logic       nop;
    logic [2:0] pad;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_MBUSY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic [PC_W-1:0]  pc4_q;
  logic             illegal_q;
  logic [CNT_W-1:0] mul_cnt;
  logic             dec_legal;
  logic             dec_mul;
  logic             mul_wait;
  logic             accept;
  logic             in_ready;
  logic             out_valid;
  logic [5:0]       op;
  logic [5:0]       fn;
  logic [4:0]       rt;

  assign op = bus.inst_i[31:26];
  assign fn = bus.inst_i[5:0];
  assign rt = bus.inst_i[20:16];

  // Decoder: every field starts at zero so nothing leaks from the previous word.
  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    dec_mul   = 1'b0;
    if (bus.inst_i == '0) begin
      dec.nop = 1'b1;
    end else begin
      case (op)
        6'h00: begin
          dec.reg_dst   = 2'd1;
          dec.reg_write = 1'b1;
          case (fn)
            6'h24:        dec.alu_ctrl = 4'd0;
            6'h25:        dec.alu_ctrl = 4'd1;
            6'h20, 6'h21: dec.alu_ctrl = 4'd2;
            6'h27:        dec.alu_ctrl = 4'd3;
            6'h26:        dec.alu_ctrl = 4'd4;
            6'h22, 6'h23: dec.alu_ctrl = 4'd6;
            6'h2A:        dec.alu_ctrl = 4'd7;
            6'h2B:        dec.alu_ctrl = 4'd14;
            6'h00: begin
              dec.alu_ctrl  = 4'd10;
              dec.alu_a_src = 2'd1;
            end
            6'h04:        dec.alu_ctrl = 4'd10;
            6'h02: begin
              dec.alu_ctrl  = 4'd13;
              dec.alu_a_src = 2'd1;
            end
            6'h06:        dec.alu_ctrl = 4'd13;
            6'h0A:        dec.reg_write_sel = 1'b1;
            6'h08: begin
              dec.reg_dst   = 2'd0;
              dec.reg_write = 1'b0;
              dec.jump      = 1'b1;
              dec.jump_sel  = 1'b1;
            end
            default:      dec_legal = 1'b0;
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0E, 6'h0F: begin
          dec.alu_b_src = 3'd1;
          dec.reg_write = 1'b1;
          case (op)
            6'h08: begin
              dec.alu_ctrl = 4'd2;
              dec.ext_sign = 1'b1;
            end
            6'h09: dec.alu_ctrl = 4'd2;
            6'h0A: begin
              dec.alu_ctrl = 4'd7;
              dec.ext_sign = 1'b1;
            end
            6'h0B: dec.alu_ctrl = 4'd14;
            6'h0E: dec.alu_ctrl = 4'd4;
            default: begin
              dec.alu_ctrl  = 4'd10;
              dec.alu_a_src = 2'd2;
            end
          endcase
        end
        6'h23: begin
          dec.alu_ctrl      = 4'd2;
          dec.alu_b_src     = 3'd1;
          dec.reg_write     = 1'b1;
          dec.mem_read      = 1'b1;
          dec.mem_to_reg    = 1'b1;
          dec.bhw           = 2'd2;
          dec.dmem_ext_sign = 1'b1;
        end
        6'h2B: begin
          dec.alu_ctrl      = 4'd2;
          dec.alu_b_src     = 3'd1;
          dec.mem_write     = 1'b1;
          dec.bhw           = 2'd2;
          dec.dmem_ext_sign = 1'b1;
        end
        6'h04: begin
          dec.alu_ctrl = 4'd6;
          dec.beq      = 1'b1;
        end
        6'h05: begin
          dec.alu_ctrl = 4'd6;
          dec.bne      = 1'b1;
        end
        6'h07: begin
          dec.alu_ctrl  = 4'd11;
          dec.alu_b_src = 3'd2;
          dec.bltz_bgtz = 1'b1;
        end
        6'h01: begin
          dec.alu_ctrl  = 4'd7;
          dec.alu_b_src = 3'd2;
          case (rt)
            5'd0:    dec.bltz_bgtz = 1'b1;
            5'd1:    dec.bgez      = 1'b1;
            default: dec_legal     = 1'b0;
          endcase
        end
        6'h02: dec.jump = 1'b1;
        6'h03: begin
          dec.jump         = 1'b1;
          dec.reg_dst      = 2'd2;
          dec.reg_data_sel = 2'd1;
          dec.reg_write    = 1'b1;
        end
        6'h1C: begin
          dec.reg_dst   = 2'd1;
          dec.reg_write = 1'b1;
          if (EN_SPECIAL2 == 0) begin
            dec_legal = 1'b0;
          end else begin
            case (fn)
              6'h02: begin
                dec.alu_ctrl = 4'd9;
                dec_mul      = 1'b1;
              end
              6'h20, 6'h21: dec.alu_ctrl = 4'd12;
              default:      dec_legal    = 1'b0;
            endcase
          end
        end
        default: dec_legal = 1'b0;
      endcase
    end
    if (!dec_legal) begin
      dec     = '0;
      dec.nop = 1'b1;
      dec_mul = 1'b0;
    end
  end

  assign mul_wait = dec_mul && (MUL_LATENCY > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_EMPTY: in_ready = 1'b1;
      S_FULL: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
      end
      default: ;
    endcase
    accept = bus.in_valid & in_ready & ~bus.flush_i;
    case (state_q)
      S_EMPTY: begin
        if (accept) state_d = mul_wait ? S_MBUSY : S_FULL;
      end
      S_FULL: begin
        if (accept)             state_d = mul_wait ? S_MBUSY : S_FULL;
        else if (bus.out_ready) state_d = S_EMPTY;
      end
      S_MBUSY: begin
        if (mul_cnt <= CNT_W'(1)) state_d = S_FULL;
      end
      default: state_d = S_EMPTY;
    endcase
    if (bus.flush_i) state_d = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      pc4_q     <= '0;
      illegal_q <= 1'b0;
      mul_cnt   <= '0;
    end else if (bus.flush_i) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      mul_cnt   <= '0;
    end else begin
      illegal_q <= accept & ~dec_legal;
      if (accept) begin
        ctrl_q <= dec;
        pc4_q  <= bus.pc4_i;
      end
      if (accept && mul_wait) begin
        mul_cnt <= CNT_W'(MUL_LATENCY - 1);
      end else if (state_q == S_MBUSY && mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.ctrl_o    = ctrl_q;
  assign bus.pc4_o     = pc4_q;
  assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// tb/tb_pipelined_decode_ctrl.sv - randomized scoreboard bench for pipelined_decode_ctrl
module tb_pipelined_decode_ctrl;

  localparam int MUL_LAT = 3;

  localparam logic [31:0] RW   = 32'h1 << 18;
  localparam logic [31:0] RWS  = 32'h1 << 17;
  localparam logic [31:0] MR   = 32'h1 << 16;
  localparam logic [31:0] MW   = 32'h1 << 15;
  localparam logic [31:0] M2R  = 32'h1 << 14;
  localparam logic [31:0] DEXT = 32'h1 << 11;
  localparam logic [31:0] EXT  = 32'h1 << 10;
  localparam logic [31:0] BEQ  = 32'h1 << 9;
  localparam logic [31:0] BNE  = 32'h1 << 8;
  localparam logic [31:0] BLT  = 32'h1 << 7;
  localparam logic [31:0] BGEZ = 32'h1 << 6;
  localparam logic [31:0] JMP  = 32'h1 << 5;
  localparam logic [31:0] JSEL = 32'h1 << 4;
  localparam logic [31:0] NOP  = 32'h1 << 3;
  localparam logic [31:0] RM   = 32'h03FF_FFC0;
  localparam logic [31:0] IM   = 32'h03FF_FFFF;
  localparam logic [31:0] BM   = 32'h03E0_FFFF;

  function automatic logic [31:0] alu(int v);  return 32'(v) << 28; endfunction
  function automatic logic [31:0] asrc(int v); return 32'(v) << 26; endfunction
  function automatic logic [31:0] bsrc(int v); return 32'(v) << 23; endfunction
  function automatic logic [31:0] dst(int v);  return 32'(v) << 21; endfunction
  function automatic logic [31:0] dsel(int v); return 32'(v) << 19; endfunction
  function automatic logic [31:0] bhw(int v);  return 32'(v) << 12; endfunction

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] mask;
    logic [31:0] exp;
    bit          mul;
    bit          ill;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] ctrl;
    bit          ill;
    bit          mul;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_decode_ctrl_if #(.INST_W(32), .PC_W(32)) bus ();

  pipelined_decode_ctrl #(
    .INST_W(32), .PC_W(32), .MUL_LATENCY(MUL_LAT), .EN_SPECIAL2(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_drained = 0;
  entry_t tbl[$];
  int     ok_idx[$];
  int     bad_idx[$];

  int     held, busy;
  bit     fresh, zero_ctrl;
  item_t  cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void add(string nm, logic [31:0] b, logic [31:0] m, logic [31:0] e,
                              bit mul, bit ill);
    entry_t x;
    x.name = nm; x.base = b; x.mask = m; x.exp = ill ? NOP : e; x.mul = mul; x.ill = ill;
    if (ill) bad_idx.push_back(tbl.size()); else ok_idx.push_back(tbl.size());
    tbl.push_back(x);
  endfunction

  function automatic void build_table();
    add("AND",   32'h0000_0024, RM, alu(0)  | dst(1) | RW, 0, 0);
    add("OR",    32'h0000_0025, RM, alu(1)  | dst(1) | RW, 0, 0);
    add("ADD",   32'h0000_0020, RM, alu(2)  | dst(1) | RW, 0, 0);
    add("ADDU",  32'h0000_0021, RM, alu(2)  | dst(1) | RW, 0, 0);
    add("NOR",   32'h0000_0027, RM, alu(3)  | dst(1) | RW, 0, 0);
    add("XOR",   32'h0000_0026, RM, alu(4)  | dst(1) | RW, 0, 0);
    add("SUB",   32'h0000_0022, RM, alu(6)  | dst(1) | RW, 0, 0);
    add("SUBU",  32'h0000_0023, RM, alu(6)  | dst(1) | RW, 0, 0);
    add("SLT",   32'h0000_002A, RM, alu(7)  | dst(1) | RW, 0, 0);
    add("SLTU",  32'h0000_002B, RM, alu(14) | dst(1) | RW, 0, 0);
    add("SLL",   32'h0000_0000, RM, alu(10) | asrc(1) | dst(1) | RW, 0, 0);
    add("SLLV",  32'h0000_0004, RM, alu(10) | dst(1) | RW, 0, 0);
    add("ROTR",  32'h0000_0002, RM, alu(13) | asrc(1) | dst(1) | RW, 0, 0);
    add("ROTRV", 32'h0000_0006, RM, alu(13) | dst(1) | RW, 0, 0);
    add("MOVZ",  32'h0000_000A, RM, dst(1) | RW | RWS, 0, 0);
    add("JR",    32'h0000_0008, RM, JMP | JSEL, 0, 0);
    add("ADDI",  32'h2000_0000, IM, alu(2)  | bsrc(1) | RW | EXT, 0, 0);
    add("ADDIU", 32'h2400_0000, IM, alu(2)  | bsrc(1) | RW, 0, 0);
    add("SLTI",  32'h2800_0000, IM, alu(7)  | bsrc(1) | RW | EXT, 0, 0);
    add("SLTIU", 32'h2C00_0000, IM, alu(14) | bsrc(1) | RW, 0, 0);
    add("XORI",  32'h3800_0000, IM, alu(4)  | bsrc(1) | RW, 0, 0);
    add("LUI",   32'h3C00_0000, IM, alu(10) | asrc(2) | bsrc(1) | RW, 0, 0);
    add("LW",    32'h8C00_0000, IM, alu(2) | bsrc(1) | RW | MR | M2R | bhw(2) | DEXT, 0, 0);
    add("SW",    32'hAC00_0000, IM, alu(2) | bsrc(1) | MW | bhw(2) | DEXT, 0, 0);
    add("BEQ",   32'h1000_0000, IM, alu(6)  | BEQ, 0, 0);
    add("BNE",   32'h1400_0000, IM, alu(6)  | BNE, 0, 0);
    add("BGTZ",  32'h1C00_0000, IM, alu(11) | bsrc(2) | BLT, 0, 0);
    add("BLTZ",  32'h0400_0000, BM, alu(7)  | bsrc(2) | BLT, 0, 0);
    add("BGEZ",  32'h0401_0000, BM, alu(7)  | bsrc(2) | BGEZ, 0, 0);
    add("J",     32'h0800_0000, IM, JMP, 0, 0);
    add("JAL",   32'h0C00_0000, IM, JMP | dst(2) | dsel(1) | RW, 0, 0);
    add("MUL",   32'h7000_0002, RM, alu(9)  | dst(1) | RW, 1, 0);
    add("CLZ",   32'h7000_0020, RM, alu(12) | dst(1) | RW, 0, 0);
    add("CLO",   32'h7000_0021, RM, alu(12) | dst(1) | RW, 0, 0);
    add("OP3F",  32'hFC00_0000, IM, 32'h0, 0, 1);
    add("ANDI",  32'h3000_0000, IM, 32'h0, 0, 1);
    add("RF3F",  32'h0000_003F, RM, 32'h0, 0, 1);
    add("S2F3F", 32'h7000_003F, RM, 32'h0, 0, 1);
    add("RIMM5", 32'h0405_0000, BM, 32'h0, 0, 1);
  endfunction

  function automatic item_t item_from(int idx, logic [31:0] inst);
    item_t it;
    it.inst = inst;
    it.pc4  = $urandom;
    if (inst == 32'h0) begin
      it.ctrl = NOP; it.ill = 1'b0; it.mul = 1'b0;
    end else begin
      it.ctrl = tbl[idx].exp; it.ill = tbl[idx].ill; it.mul = tbl[idx].mul;
    end
    return it;
  endfunction

  function automatic item_t named(string nm, logic [31:0] inst);
    int idx = 0;
    foreach (tbl[i]) if (tbl[i].name == nm) idx = i;
    return item_from(idx, inst);
  endfunction

  function automatic item_t rand_item();
    int r = $urandom_range(0, 9);
    int idx;
    if (r == 0) return item_from(0, 32'h0);
    if (r < 3) idx = bad_idx[$urandom_range(0, bad_idx.size() - 1)];
    else       idx = ok_idx[$urandom_range(0, ok_idx.size() - 1)];
    return item_from(idx, tbl[idx].base | ($urandom & tbl[idx].mask));
  endfunction

  task automatic model_reset();
    held = 0; busy = 0; fresh = 1'b0; zero_ctrl = 1'b1;
  endtask

  // One clock: drive at negedge, compare against the occupancy model, advance at posedge.
  task automatic step(input bit v, input item_t it, input bit ordy, input bit fl);
    bit ev, eir, acc, drn;
    @(negedge clk);
    bus.in_valid  = v;
    bus.inst_i    = it.inst;
    bus.pc4_i     = it.pc4;
    bus.out_ready = ordy;
    bus.flush_i   = fl;
    #1;
    ev  = (held != 0) && (busy == 0);
    eir = (held == 0) || (ev && ordy);
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("in_ready", 32'(bus.in_ready), 32'(eir));
    check("illegal_o", 32'(bus.illegal_o), 32'(fresh && cur.ill));
    if (ev) begin
      check("ctrl_o", bus.ctrl_o, cur.ctrl);
      check("pc4_o", bus.pc4_o, cur.pc4);
    end else if (held == 0 && zero_ctrl) begin
      check("ctrl_zero", bus.ctrl_o, 32'h0);
    end
    if (bus.out_valid && ordy) n_drained++;
    acc = v && eir && !fl;
    drn = ev && ordy;
    @(posedge clk);
    if (fl) begin
      held = 0; busy = 0; fresh = 1'b0; zero_ctrl = 1'b1;
    end else begin
      fresh = 1'b0;
      if (busy > 0) busy--;
      if (drn) held = 0;
      if (acc) begin
        held = 1; cur = it; fresh = 1'b1; zero_ctrl = 1'b0;
        busy = it.mul ? MUL_LAT - 1 : 0;
      end
    end
  endtask

  item_t idle_it, add_it, it;
  int    snap;

  initial begin
    build_table();
    idle_it = item_from(0, 32'h0);
    add_it  = named("ADD", 32'h0022_1820);
    bus.in_valid = 1'b0; bus.inst_i = '0; bus.pc4_i = '0;
    bus.out_ready = 1'b0; bus.flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_ctrl", bus.ctrl_o, 32'h0);
    check("rst_pc4", bus.pc4_o, 32'h0);
    check("rst_illegal", 32'(bus.illegal_o), 32'h0);

    step(1, add_it, 1, 0);
    #1;
    check("add_alu", 32'(bus.ctrl_o[31:28]), 32'd2);
    check("add_reg_dst", 32'(bus.ctrl_o[22:21]), 32'd1);
    check("add_reg_write", 32'(bus.ctrl_o[18]), 32'd1);
    check("add_in_ready", 32'(bus.in_ready), 32'd1);

    snap = n_drained;
    for (int i = 0; i < 8; i++) step(1, named("ADD", 32'h0000_0020 | (32'(i) << 11)), 1, 0);
    step(0, idle_it, 1, 0);
    check("stream_rate", 32'(n_drained - snap), 32'd9);

    step(1, named("MUL", 32'h7022_1802), 1, 0);
    for (int i = 0; i < 3; i++) step(1, add_it, 1, 0);
    step(0, idle_it, 1, 0);

    step(1, named("LW", 32'h8C22_0004), 0, 0);
    for (int i = 0; i < 5; i++) step(1, add_it, 0, 0);
    step(0, idle_it, 1, 0);
    step(0, idle_it, 1, 0);

    step(1, add_it, 0, 0);
    step(1, named("SUB", 32'h0022_1822), 0, 1);
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check("flush_ctrl", bus.ctrl_o, 32'h0);
    step(0, idle_it, 1, 0);

    step(1, named("OP3F", 32'hFC00_1234), 0, 0);
    #1;
    check("ill_pulse", 32'(bus.illegal_o), 32'h1);
    check("ill_nop", 32'(bus.ctrl_o[3]), 32'h1);
    check("ill_reg_write", 32'(bus.ctrl_o[18]), 32'h0);
    check("ill_mem_write", 32'(bus.ctrl_o[15]), 32'h0);
    step(0, idle_it, 1, 0);
    step(0, idle_it, 1, 0);

    step(1, named("MUL", 32'h7022_1802), 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mbusy_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_mbusy_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_mbusy_ctrl", bus.ctrl_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      it = rand_item();
      step($urandom_range(0, 3) != 0, it, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    step(0, idle_it, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
